// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU writeback (0) and load/multi-cycle writeback (1).
// Latency: ACK in the same cycle as REQ; WE3/WR3/WD3 one cycle after ACK; FWD1/FWD2 combinational off the registered write.
// Backpressure: at most one grant per cycle; the loser sees ACK=0 and holds REQ/ADDR/DATA until acked.
module regfile_write_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ0,
  input  logic [AW-1:0] ADDR0,
  input  logic [DW-1:0] DATA0,
  output logic          ACK0,
  input  logic          REQ1,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] DATA1,
  output logic          ACK1,
  input  logic [AW-1:0] RR1,
  input  logic [AW-1:0] RR2,
  output logic          WE3,
  output logic [AW-1:0] WR3,
  output logic [DW-1:0] WD3,
  output logic          FWD1,
  output logic          FWD2,
  output logic          PRIO
);

  logic          grant0;
  logic          grant1;
  logic          any_grant;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;

  // Grant selection: a lone requester always wins, a contested cycle goes to PRIO.
  // Grants depend only on requests and PRIO, never on the registered write stage.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (RST) begin
      if (REQ0 && REQ1) begin
        grant0 = ~PRIO;
        grant1 = PRIO;
      end else begin
        grant0 = REQ0;
        grant1 = REQ1;
      end
    end
  end

  assign ACK0      = grant0;
  assign ACK1      = grant1;
  assign any_grant = grant0 | grant1;

  // Winner mux: address and data of whichever requester holds the grant.
  always_comb begin
    win_addr = ADDR0;
    win_data = DATA0;
    if (grant1) begin
      win_addr = ADDR1;
      win_data = DATA1;
    end
  end

  // Write stage and priority: capture the winning write; x0 writes consume the slot without enabling.
  // Reset discards any pending write so nothing lands in the register file on the next edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      WE3  <= 1'b0;
      WR3  <= '0;
      WD3  <= '0;
      PRIO <= 1'b0;
    end else if (any_grant) begin
      WE3  <= (win_addr != '0);
      WR3  <= win_addr;
      WD3  <= win_data;
      PRIO <= grant0;
    end else begin
      WE3  <= 1'b0;
    end
  end

  // Forwarding: the uncommitted write replaces a read of the same non-zero register.
  assign FWD1 = WE3 && (WR3 == RR1) && (RR1 != '0);
  assign FWD2 = WE3 && (WR3 == RR2) && (RR2 != '0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [DW-1:0] data0 = '0;
  logic          ack0;
  logic          req1 = 1'b0;
  logic [AW-1:0] addr1 = '0;
  logic [DW-1:0] data1 = '0;
  logic          ack1;
  logic [AW-1:0] rr1 = '0;
  logic [AW-1:0] rr2 = '0;
  logic          we3;
  logic [AW-1:0] wr3;
  logic [DW-1:0] wd3;
  logic          fwd1;
  logic          fwd2;
  logic          prio;

  int vectors = 0;
  int miscompares = 0;
  bit done = 1'b0;

  regfile_write_arbiter #(.DW(DW), .AW(AW)) dut (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .ADDR0(addr0), .DATA0(data0), .ACK0(ack0),
    .REQ1(req1), .ADDR1(addr1), .DATA1(data1), .ACK1(ack1),
    .RR1(rr1), .RR2(rr2),
    .WE3(we3), .WR3(wr3), .WD3(wd3),
    .FWD1(fwd1), .FWD2(fwd2), .PRIO(prio)
  );

  always #5 clk = ~clk;

  // Behavioural model: who is owed the next contested slot, and the write waiting to commit.
  int            m_owed = 0;
  bit            m_pending = 1'b0;
  int            m_reg = 0;
  logic [DW-1:0] m_val = '0;
  logic [DW-1:0] m_rf [32];
  logic [DW-1:0] tb_rf [32];

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_rf[i]  = '0;
      tb_rf[i] = '0;
    end
  end

  function automatic int pick_winner();
    if (!rst) return -1;
    if (req0 && req1) return m_owed;
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  // Model update: commit the pending write, then record this edge's winner.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owed = 0;
      m_pending = 1'b0;
      m_reg = 0;
      m_val = '0;
    end else begin
      int w;
      if (m_pending) m_rf[m_reg] = m_val;
      w = pick_winner();
      if (w == 0) begin
        m_reg = int'(addr0); m_val = data0; m_pending = (addr0 != 0); m_owed = 1;
      end else if (w == 1) begin
        m_reg = int'(addr1); m_val = data1; m_pending = (addr1 != 0); m_owed = 0;
      end else begin
        m_pending = 1'b0;
      end
    end
  end

  // A register file fed only by the DUT's write port.
  always @(posedge clk) begin
    if (we3) tb_rf[wr3] <= wd3;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (!done) begin
      int w;
      w = pick_winner();
      chk("m_ack0", ack0, (w == 0));
      chk("m_ack1", ack1, (w == 1));
      chk("m_we3", we3, m_pending);
      if (m_pending) begin
        chk("m_wr3", wr3, m_reg);
        chk("m_wd3", wd3, m_val);
      end
      chk("m_prio", prio, m_owed);
      chk("m_fwd1", fwd1, m_pending && (m_reg == int'(rr1)) && (rr1 != 0));
      chk("m_fwd2", fwd2, m_pending && (m_reg == int'(rr2)) && (rr2 != 0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int grants[$];

  initial begin
    #1 rst = 1'b0;
    req0 = 1'b1; addr0 = 5'd2; data0 = 32'h1;
    step();
    #1;
    chk("rst_ack0", ack0, 0);
    chk("rst_we3", we3, 0);
    chk("rst_wr3", wr3, 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_prio", prio, 0);
    chk("rst_fwd1", fwd1, 0);
    req0 = 1'b0;
    step();
    rst = 1'b1;

    // Single write from requester 0.
    step();
    req0 = 1'b1; addr0 = 5'd5; data0 = 32'hDEADBEEF;
    #1 chk("t1_ack0", ack0, 1);
    chk("t1_ack1", ack1, 0);
    step();
    req0 = 1'b0;
    #1 chk("t1_we3", we3, 1);
    chk("t1_wr3", wr3, 5);
    chk("t1_wd3", wd3, 32'hDEADBEEF);
    chk("t1_prio", prio, 1);
    step();
    #1 chk("t1_we3_off", we3, 0);

    // Both requesting from reset: 0 first, then 1.
    rst = 1'b0;
    step();
    rst = 1'b1;
    req0 = 1'b1; addr0 = 5'd3; data0 = 32'h11;
    req1 = 1'b1; addr1 = 5'd4; data1 = 32'h22;
    #1 chk("t2_ack0", ack0, 1);
    chk("t2_ack1_wait", ack1, 0);
    step();
    req0 = 1'b0;
    #1 chk("t2_ack1", ack1, 1);
    chk("t2_wr3_a", wr3, 3);
    chk("t2_wd3_a", wd3, 32'h11);
    step();
    req1 = 1'b0;
    #1 chk("t2_we3_b", we3, 1);
    chk("t2_wr3_b", wr3, 4);
    chk("t2_wd3_b", wd3, 32'h22);
    step();
    #1 chk("t2_we3_off", we3, 0);

    // Six contested grants with fresh data after each ack.
    req0 = 1'b1; addr0 = 5'd10; data0 = 32'hA000;
    req1 = 1'b1; addr1 = 5'd20; data1 = 32'hB000;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (ack0) grants.push_back(0);
      else if (ack1) grants.push_back(1);
      else grants.push_back(-1);
      step();
      if (grants[k] == 0) begin
        addr0 = addr0 + 5'd1; data0 = data0 + 32'h1;
      end else begin
        addr1 = addr1 + 5'd1; data1 = data1 + 32'h1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 6; k++) chk("t3_alternate", grants[k], k % 2);

    // Write to x0: acked, never enabled, no forwarding.
    step();
    req1 = 1'b1; addr1 = 5'd0; data1 = 32'hFFFFFFFF;
    rr1 = 5'd0; rr2 = 5'd0;
    #1 chk("t4_ack1", ack1, 1);
    step();
    req1 = 1'b0;
    #1 chk("t4_we3", we3, 0);
    chk("t4_fwd1", fwd1, 0);
    chk("t4_fwd2", fwd2, 0);

    // Forwarding of the uncommitted write.
    step();
    req0 = 1'b1; addr0 = 5'd7; data0 = 32'h1234;
    #1 chk("t5_ack0", ack0, 1);
    step();
    req0 = 1'b0; rr1 = 5'd7; rr2 = 5'd8;
    #1 chk("t5_fwd1", fwd1, 1);
    chk("t5_fwd2", fwd2, 0);
    chk("t5_wd3", wd3, 32'h1234);
    step();
    rr1 = 5'd0; rr2 = 5'd0;

    // Reset between grant and commit discards the write.
    step();
    req0 = 1'b1; addr0 = 5'd9; data0 = 32'hCAFE;
    #1 chk("t6_ack0", ack0, 1);
    step();
    req0 = 1'b0;
    #1 chk("t6_we3_pend", we3, 1);
    #1 rst = 1'b0;
    #1 chk("t6_we3_rst", we3, 0);
    chk("t6_prio_rst", prio, 0);
    step();
    rst = 1'b1;
    req1 = 1'b1; addr1 = 5'd6; data1 = 32'h66;
    #1 chk("t6_ack1", ack1, 1);
    step();
    req1 = 1'b0;
    #1 chk("t6_wr3", wr3, 6);
    chk("t6_we3", we3, 1);
    step();
    step();
    chk("t6_reg9", tb_rf[9], 0);
    chk("t6_reg6", tb_rf[6], 32'h66);
    chk("t1_reg5", tb_rf[5], 32'hDEADBEEF);
    for (int i = 0; i < 32; i++) chk("rf_contents", tb_rf[i], m_rf[i]);

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port (WE3/WR3/WD3) between two writeback requesters: the ALU writeback path (requester 0) and the load/multi-cycle unit writeback path (requester 1). Round-robin arbitration with a req/ack handshake; the winning write is registered for one cycle before driving the register file. Sits between the writeback sources and the register file's write port. Also exposes forwarding hits so the read path can bypass a write not yet committed.

## Interface
Parameters:
- DW, 32, data width of a register write
- AW, 5, register address width

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-low (RST=0 resets)
- REQ0  in  1  requester 0 write request, held until ACK0
- ADDR0  in  AW  requester 0 destination register
- DATA0  in  DW  requester 0 write data
- ACK0  out  1  requester 0 granted this cycle (combinational)
- REQ1, ADDR1, DATA1, ACK1: same for requester 1
- RR1  in  AW  read address of register-file port 1
- RR2  in  AW  read address of register-file port 2
- WE3  out  1  register-file write enable (registered)
- WR3  out  AW  register-file write address (registered)
- WD3  out  DW  register-file write data (registered)
- FWD1  out  1  WD3 must replace RD1 (combinational)
- FWD2  out  1  WD3 must replace RD2 (combinational)
- PRIO  out  1  requester holding priority next contested cycle (registered)

## Operation
- Per cycle at most one grant. Requester with REQ=1 and ACK=1 is the winner.
- Only REQ0: ACK0=1. Only REQ1: ACK1=1. Neither: no ACK.
- Both: grant requester PRIO; the other sees ACK=0 and must hold REQ/ADDR/DATA stable.
- PRIO update on any grant: PRIO <= index of the non-winner. No grant: PRIO unchanged.
- Capture on rising edge: if a grant occurred, WR3 <= winner ADDR, WD3 <= winner DATA, WE3 <= (winner ADDR != 0); otherwise WE3 <= 0, WR3/WD3 hold.
- Writes to x0 are acked and consume the slot but never assert WE3.
- FWD1 = WE3 & (WR3 == RR1) & (RR1 != 0); FWD2 likewise with RR2.
- ACK0/ACK1 forced to 0 while RST=0.
- Requester may drop REQ only after its ACK; dropping earlier is a protocol violation (no guarantee).

## Timing
- Reset values: WE3=0, WR3=0, WD3=0, PRIO=0; ACK0=ACK1=0, FWD1=FWD2=0.
- Grant latency: ACK in the same cycle REQ is seen, if granted.
- Write latency: WE3 asserted the cycle after ACK; register file commits at the following rising edge, so value is readable from the register file 2 cycles after ACK and via FWD 1 cycle after ACK.
- Throughput: one write per cycle; two continuous requesters alternate 0,1,0,1 starting from PRIO.
- Back-to-back writes to same register: later grant wins; WD3 reflects most recent.
- Async reset mid-operation: pending registered write discarded (WE3=0 immediately on RST falling), PRIO=0; no register-file write occurs on the next edge.
- After RST deasserts, first edge may capture a grant normally.
- No combinational path from WE3/WR3/WD3 back to ACK.

## Test plan
- After reset, REQ0=1 ADDR0=5 DATA0=0xDEADBEEF for one cycle -> ACK0=1 same cycle; next cycle WE3=1 WR3=5 WD3=0xDEADBEEF, PRIO=1; following cycle WE3=0.
- REQ0 and REQ1 held high from reset (ADDR0=3/0x11, ADDR1=4/0x22) -> ACK0 cycle 1, ACK1 cycle 2 (REQ0 dropped after ack); WE3 pulses WR3=3 then WR3=4 on consecutive cycles.
- Both requesters continuously valid for 6 grants with fresh data each ack -> grants alternate 0,1,0,1,0,1, no requester starved.
- REQ1=1 ADDR1=0 DATA1=0xFFFFFFFF -> ACK1=1; next cycle WE3=0, FWD1=FWD2=0 with RR1=RR2=0.
- Write ADDR0=7 DATA0=0x1234; cycle after ack with RR1=7, RR2=8 -> FWD1=1, FWD2=0, WD3=0x1234.
- Grant to ADDR0=9 then pull RST low before the next rising edge -> WE3=0 immediately, PRIO=0, register 9 unchanged; after release single REQ1 is acked normally.
